div_issue_sequencer: RTL and testbench

//  Front-end for the radix-2 SRT divider datapath/control pair. Accepts divide requests over

---
 rtl/div_issue_if.sv | 58 +++++
 rtl/div_issue_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_div_issue_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_if.sv
// ---------------------------------------------------------------------------
// div_issue_if
// Bundles the three handshake groups around the divider issue sequencer:
//   req_*  : request channel (valid/ready) from the producer into the FIFO
//   div_*  : launch/completion link to the radix-2 SRT divider control
//   rsp_*  : response channel (valid/ready) to the consumer, plus error flag
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (producer, divider and consumer together)
// ---------------------------------------------------------------------------
interface div_issue_if #(
    parameter int parallelism = 32
);
    // Request channel
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_usigned;
    logic [parallelism-1:0] req_dividend;
    logic [parallelism-1:0] req_divisor;

    // Divider link
    logic                   div_start;
    logic                   div_usigned;
    logic [parallelism-1:0] div_dividend;
    logic [parallelism-1:0] div_divisor;
    logic                   div_done;
    logic [parallelism-1:0] div_quotient;
    logic [parallelism-1:0] div_reminder;

    // Response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [parallelism-1:0] rsp_quotient;
    logic [parallelism-1:0] rsp_reminder;
    logic                   rsp_divByZero;
    logic                   rsp_bypass;
    logic                   err_spurDone;

    modport slave (
        input  req_valid, req_usigned, req_dividend, req_divisor,
        output req_ready,
        output div_start, div_usigned, div_dividend, div_divisor,
        input  div_done, div_quotient, div_reminder,
        output rsp_valid, rsp_quotient, rsp_reminder, rsp_divByZero, rsp_bypass,
        input  rsp_ready,
        output err_spurDone
    );

    modport master (
        output req_valid, req_usigned, req_dividend, req_divisor,
        input  req_ready,
        input  div_start, div_usigned, div_dividend, div_divisor,
        output div_done, div_quotient, div_reminder,
        input  rsp_valid, rsp_quotient, rsp_reminder, rsp_divByZero, rsp_bypass,
        output rsp_ready,
        input  err_spurDone
    );
endinterface

// File: rtl/div_issue_sequencer.sv
// ---------------------------------------------------------------------------
// div_issue_sequencer
// Front-end for the radix-2 SRT divider. Requests are queued in a small FIFO,
// popped one at a time, and either resolved locally (divide-by-zero, signed
// MIN/-1 overflow) or launched on the divider with a one-cycle start pulse.
// Each result is held on the response channel until the consumer takes it,
// so at most one request is in flight.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (shared with the divider)
//   bus_if : div_issue_if.slave -- request, divider and response channels
// ---------------------------------------------------------------------------
module div_issue_sequencer #(
    parameter int parallelism = 32,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    div_issue_if.slave   bus_if
);
    localparam int P  = parallelism;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [P-1:0] MIN_NEG  = {1'b1, {(P-1){1'b0}}};

    typedef struct packed {
        logic         usigned;
        logic [P-1:0] dividend;
        logic [P-1:0] divisor;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    req_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            ready_q;
    state_t          state_q;

    logic push, pop;
    req_t head;

    // ready_q is a registered "not full", so req_ready has no combinational
    // path from anything; it is low while in reset and rises on the first edge.
    assign push = bus_if.req_valid & ready_q;
    // Pop only reads the registered count, so an entry written on edge N is
    // first seen (and popped) on edge N+1 -- no fall-through.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: default assignment first so every path drives count_d; a
        // missing branch in always_comb would otherwise infer a latch.
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: storage array has no reset; validity is tracked by count_q and the
    // pointers, so resetting the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{usigned:  bus_if.req_usigned,
                                 dividend: bus_if.req_dividend,
                                 divisor:  bus_if.req_divisor};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
        end
    end

    // ------------------------------------------------------------------
    // Classification of the FIFO head (used only in the pop cycle)
    // ------------------------------------------------------------------
    logic head_div0, head_ovf;
    assign head_div0 = (head.divisor == '0);
    assign head_ovf  = !head.usigned && (head.dividend == MIN_NEG) && (head.divisor == '1);

    // ------------------------------------------------------------------
    // Issue FSM with registered outputs
    // ------------------------------------------------------------------
    logic         div_start_q;
    logic         div_usigned_q;
    logic [P-1:0] div_dividend_q, div_divisor_q;
    logic         rsp_valid_q;
    logic [P-1:0] rsp_quotient_q, rsp_reminder_q;
    logic         rsp_div0_q, rsp_bypass_q;
    logic         err_spur_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            div_start_q    <= 1'b0;
            div_usigned_q  <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_quotient_q <= '0;
            rsp_reminder_q <= '0;
            rsp_div0_q     <= 1'b0;
            rsp_bypass_q   <= 1'b0;
            err_spur_q     <= 1'b0;
        end else begin
            // A completion pulse we are not waiting for is dropped, but
            // remembered until the next reset.
            if (bus_if.div_done && (state_q != S_WAIT)) begin
                err_spur_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        // Operand registers change only here, so the divider
                        // sees stable inputs through ISSUE and WAIT.
                        div_usigned_q  <= head.usigned;
                        div_dividend_q <= head.dividend;
                        div_divisor_q  <= head.divisor;
                        if (head_div0) begin
                            // Divide-by-zero wins over overflow.
                            rsp_quotient_q <= '1;
                            rsp_reminder_q <= head.dividend;
                            rsp_div0_q     <= 1'b1;
                            rsp_bypass_q   <= 1'b1;
                            rsp_valid_q    <= 1'b1;
                            state_q        <= S_HOLD;
                        end else if (head_ovf) begin
                            rsp_quotient_q <= head.dividend;
                            rsp_reminder_q <= '0;
                            rsp_bypass_q   <= 1'b1;
                            rsp_valid_q    <= 1'b1;
                            state_q        <= S_HOLD;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    div_start_q <= 1'b0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus_if.div_done) begin
                        rsp_quotient_q <= bus_if.div_quotient;
                        rsp_reminder_q <= bus_if.div_reminder;
                        rsp_valid_q    <= 1'b1;
                        state_q        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus_if.rsp_ready) begin
                        rsp_valid_q    <= 1'b0;
                        rsp_quotient_q <= '0;
                        rsp_reminder_q <= '0;
                        rsp_div0_q     <= 1'b0;
                        rsp_bypass_q   <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_if.req_ready     = ready_q;
    assign bus_if.div_start     = div_start_q;
    assign bus_if.div_usigned   = div_usigned_q;
    assign bus_if.div_dividend  = div_dividend_q;
    assign bus_if.div_divisor   = div_divisor_q;
    assign bus_if.rsp_valid     = rsp_valid_q;
    assign bus_if.rsp_quotient  = rsp_quotient_q;
    assign bus_if.rsp_reminder  = rsp_reminder_q;
    assign bus_if.rsp_divByZero = rsp_div0_q;
    assign bus_if.rsp_bypass    = rsp_bypass_q;
    assign bus_if.err_spurDone  = err_spur_q;

endmodule

// File: tb/tb_div_issue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_issue_sequencer
// Directed stimulus with a scoreboard: the driver pushes hand-computed
// expected responses, a divider stand-in answers start pulses, and a monitor
// pops and compares every response the sequencer presents.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_div_issue_sequencer;
    localparam int P   = 32;
    localparam int LAT = 3;   // divider stand-in: done LAT cycles after start

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_issue_if #(.parallelism(P)) bus_if ();

    div_issue_sequencer #(.parallelism(P), .FIFO_DEPTH(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [P-1:0] q;
        logic [P-1:0] r;
        logic         dz;
        logic         bp;
        int           vld_cyc;   // expected first-visible cycle for bypass, -1 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];            // expected start cycle per issued request, -1 = unchecked

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------
    // Divider stand-in
    // -------------------------------------------------------------------
    bit           busy = 1'b0;
    int           cnt = 0;
    int           last_done = -10;
    logic         op_us;
    logic [P-1:0] op_a, op_b, qv, rv;
    bit           spur_tog = 1'b0;
    bit           spur_ack = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            cnt  = 0;
            bus_if.div_done     = 1'b0;
            bus_if.div_quotient = '0;
            bus_if.div_reminder = '0;
        end else begin
            bus_if.div_done = 1'b0;
            if (spur_tog != spur_ack) begin
                spur_ack = spur_tog;
                bus_if.div_done = 1'b1;
            end
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    check("operands_stable",
                          {bus_if.div_usigned, bus_if.div_dividend, bus_if.div_divisor},
                          {op_us, op_a, op_b});
                    if (op_b == '0) begin
                        qv = '1;
                        rv = op_a;
                    end else if (op_us) begin
                        qv = op_a / op_b;
                        rv = op_a % op_b;
                    end else begin
                        qv = $signed(op_a) / $signed(op_b);
                        rv = $signed(op_a) % $signed(op_b);
                    end
                    bus_if.div_quotient = qv;
                    bus_if.div_reminder = rv;
                    bus_if.div_done     = 1'b1;
                    last_done = cyc;
                end
            end
            if (bus_if.div_start) begin
                if (start_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    int s;
                    s = start_q.pop_front();
                    if (s >= 0) check("start_latency", cyc, s);
                end
                op_us = bus_if.div_usigned;
                op_a  = bus_if.div_dividend;
                op_b  = bus_if.div_divisor;
                busy  = 1'b1;
                cnt   = LAT;
            end
        end
    end

    // -------------------------------------------------------------------
    // Response monitor
    // -------------------------------------------------------------------
    bit          in_rsp = 1'b0;
    bit          hold_pend = 1'b0;
    logic [65:0] saved, cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp    = 1'b0;
            hold_pend = 1'b0;
        end else if (bus_if.rsp_valid) begin
            cur = {bus_if.rsp_quotient, bus_if.rsp_reminder,
                   bus_if.rsp_divByZero, bus_if.rsp_bypass};
            if (hold_pend) check("rsp_stable", cur, saved);
            if (!in_rsp) begin
                in_rsp = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else if (!exp_q[0].bp) begin
                    check("rsp_after_done", cyc, last_done + 1);
                end else if (exp_q[0].vld_cyc >= 0) begin
                    check("bypass_latency", cyc, exp_q[0].vld_cyc);
                end
            end
            if (bus_if.rsp_ready) begin
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_quotient",  bus_if.rsp_quotient,  e.q);
                    check("rsp_reminder",  bus_if.rsp_reminder,  e.r);
                    check("rsp_divByZero", bus_if.rsp_divByZero, e.dz);
                    check("rsp_bypass",    bus_if.rsp_bypass,    e.bp);
                end
                in_rsp    = 1'b0;
                hold_pend = 1'b0;
            end else begin
                saved     = cur;
                hold_pend = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------
    // Driver helpers (called at posedge + 1)
    // -------------------------------------------------------------------
    task automatic send(input logic us, input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic [P-1:0] q, input logic [P-1:0] r,
                        input logic dz, input logic bp, input bit lat_chk);
        exp_t e;
        int   acc;
        int   guard;
        bus_if.req_valid    = 1'b1;
        bus_if.req_usigned  = us;
        bus_if.req_dividend = a;
        bus_if.req_divisor  = b;
        guard = 0;
        @(negedge clk);
        while (!bus_if.req_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!bus_if.req_ready) check("req_accept_timeout", 0, 1);
        acc       = cyc + 1;   // edge that samples the handshake
        e.q       = q;
        e.r       = r;
        e.dz      = dz;
        e.bp      = bp;
        e.vld_cyc = (bp && lat_chk) ? acc + 1 : -1;
        exp_q.push_back(e);
        if (!bp) start_q.push_back(lat_chk ? acc + 1 : -1);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || start_q.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", exp_q.size() + start_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"},
              {bus_if.req_ready, bus_if.div_start, bus_if.div_usigned, bus_if.rsp_valid,
               bus_if.rsp_divByZero, bus_if.rsp_bypass, bus_if.err_spurDone}, 0);
        check({tag, "_ops"}, {bus_if.div_dividend, bus_if.div_divisor}, 0);
        check({tag, "_rsp"}, {bus_if.rsp_quotient, bus_if.rsp_reminder}, 0);
    endtask

    // -------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------
    initial begin
        bus_if.req_valid    = 1'b0;
        bus_if.req_usigned  = 1'b0;
        bus_if.req_dividend = '0;
        bus_if.req_divisor  = '0;
        bus_if.rsp_ready    = 1'b1;

        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus_if.req_ready, 1);

        // Unsigned 100/7 and signed -7/2 through the divider
        send(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
        drain();
        send(1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        drain();

        // Divide-by-zero resolved locally
        send(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b1, 1'b1);
        drain();

        // MIN / -1: bypass when signed, issued when unsigned
        send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b1);
        drain();
        send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-to-back under backpressure
        bus_if.rsp_ready = 1'b0;
        send(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        send(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, 1'b0);
        send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        check("ready_when_full", bus_if.req_ready, 0);
        repeat (12) @(posedge clk);
        #1;
        check("ready_still_full", bus_if.req_ready, 0);
        bus_if.rsp_ready = 1'b1;
        drain();
        check("ready_after_drain", bus_if.req_ready, 1);

        // Reset while waiting on the divider
        send(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 1'b1);
        begin
            int g;
            g = 0;
            while (!busy && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("divider_launched", busy, 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        start_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_mid_reset", bus_if.req_ready, 1);
        check("err_clear_after_reset", bus_if.err_spurDone, 0);

        // Late completion pulse while idle
        spur_tog = ~spur_tog;
        repeat (2) @(negedge clk);
        check("err_spur_set", bus_if.err_spurDone, 1);
        check("no_rsp_for_spur", bus_if.rsp_valid, 0);
        @(posedge clk);
        #1;

        // Normal traffic afterwards; the error flag stays sticky
        send(1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1);
        drain();
        check("err_sticky", bus_if.err_spurDone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
